// File: rtl/data_memory_ctrl.sv
// Handshaked byte-addressed data memory for the CPU load/store path.
// Byte/half/word access with sign/zero extension, misalignment detection and a post-reset clear sweep.
module data_memory_ctrl #(
  parameter int ADDR_W        = 12,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              init_done
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Illegal size, or halfword/word not naturally aligned within the word.
  function automatic logic access_error(input logic [1:0] size, input logic [1:0] lane);
    logic err;
    case (size)
      2'b00:   err = 1'b0;
      2'b01:   err = lane[0];
      2'b10:   err = (lane != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data onto every lane; byte enables pick the live ones.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      2'b10:   d = wdata;
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      2'b10:   r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              init_done_q, init_done_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;

  logic [31:0]       mem_q [DEPTH];

  logic              accept_s;
  logic              req_err_s;
  logic [IDX_W-1:0]  req_idx_s;
  logic [1:0]        lane_s;
  logic [31:0]       rd_word_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  mem_idx_s;
  logic [3:0]        mem_be_s;
  logic [31:0]       mem_wdata_s;

  // State and control registers; the array itself is never reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Next state: leave INIT once the last word is cleared (or at once with no sweep).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (!INIT_ON_RESET || (idx_q == {IDX_W{1'b1}})) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Datapath and outputs: sweep writes in INIT, request handling in RUN.
  always_comb begin
    req_idx_s   = req_addr[ADDR_W-1:2];
    lane_s      = req_addr[1:0];
    req_err_s   = access_error(req_size, lane_s);
    accept_s    = req_valid & init_done_q;
    rd_word_s   = mem_q[req_idx_s];
    mem_we_s    = 1'b0;
    mem_idx_s   = req_idx_s;
    mem_be_s    = 4'b0000;
    mem_wdata_s = 32'h0000_0000;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    rsp_valid_d = accept_s;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      ST_INIT: begin
        if (INIT_ON_RESET) begin
          mem_we_s    = 1'b1;
          mem_idx_s   = idx_q;
          mem_be_s    = 4'b1111;
          idx_d       = idx_q + 1'b1;
          init_done_d = (idx_q == {IDX_W{1'b1}});
        end else begin
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        init_done_d = 1'b1;
        if (accept_s) begin
          rsp_error_d = req_err_s;
          if (req_err_s || req_we) begin
            rsp_rdata_d = 32'h0000_0000;
          end else begin
            rsp_rdata_d = load_extract(rd_word_s, req_size, lane_s, req_unsigned);
          end
          if (req_we && !req_err_s) begin
            mem_we_s    = 1'b1;
            mem_be_s    = byte_enables(req_size, lane_s);
            mem_wdata_s = store_lanes(req_size, req_wdata);
          end else begin
            mem_we_s    = 1'b0;
          end
        end else begin
          rsp_error_d = rsp_error_q;
        end
      end
      default: begin
        init_done_d = 1'b0;
      end
    endcase
  end

  // Byte-enabled array write port.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be_s[b]) begin
          mem_q[mem_idx_s][8*b +: 8] <= mem_wdata_s[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = init_done_q;
  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl with ADDR_W=6 (16 words).
module tb_data_memory_ctrl;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  data_memory_ctrl #(.ADDR_W(6), .INIT_ON_RESET(1'b1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .init_done    (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [5:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  // Single request followed by an idle cycle; checks the response one edge later.
  task automatic single(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [5:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    drive(we, size, uns, addr, wdata);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_error"}, {31'd0, rsp_error}, {31'd0, exp_err});
  endtask

  task automatic sweep_and_check(input string tag);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 15) begin
        check({tag, "_done15"}, {31'd0, init_done}, 32'd0);
        check({tag, "_ready15"}, {31'd0, req_ready}, 32'd0);
      end else if (i == 16) begin
        check({tag, "_done16"}, {31'd0, init_done}, 32'd1);
        check({tag, "_ready16"}, {31'd0, req_ready}, 32'd1);
      end else begin
        check({tag, "_busy"}, {31'd0, init_done}, 32'd0);
      end
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 6'h00;
    req_wdata    = 32'h0000_0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_done", {31'd0, init_done}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0000_0000);

    // Request held during INIT must be ignored.
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 2'b10, 1'b0, 6'h04, 32'hFFFF_FFFF);
    sweep_and_check("init");
    req_valid = 1'b0;
    check("init_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check("init_idle", {31'd0, rsp_valid}, 32'd0);

    single("ld3c", 1'b0, 2'b10, 1'b0, 6'h3C, 32'h0, 32'h0000_0000, 1'b0);
    single("ld04", 1'b0, 2'b10, 1'b0, 6'h04, 32'h0, 32'h0000_0000, 1'b0);

    single("st10", 1'b1, 2'b10, 1'b0, 6'h10, 32'h8899_AABB, 32'h0000_0000, 1'b0);
    single("lb13", 1'b0, 2'b00, 1'b0, 6'h13, 32'h0, 32'hFFFF_FF88, 1'b0);
    single("lbu10", 1'b0, 2'b00, 1'b1, 6'h10, 32'h0, 32'h0000_00BB, 1'b0);
    single("lh12", 1'b0, 2'b01, 1'b0, 6'h12, 32'h0, 32'hFFFF_8899, 1'b0);
    single("lhu12", 1'b0, 2'b01, 1'b1, 6'h12, 32'h0, 32'h0000_8899, 1'b0);
    single("lbu11", 1'b0, 2'b00, 1'b1, 6'h11, 32'h0, 32'h0000_00AA, 1'b0);
    single("lh10", 1'b0, 2'b01, 1'b0, 6'h10, 32'h0, 32'hFFFF_AABB, 1'b0);

    single("sb11", 1'b1, 2'b00, 1'b0, 6'h11, 32'h1234_56A5, 32'h0000_0000, 1'b0);
    single("lw10", 1'b0, 2'b10, 1'b1, 6'h10, 32'h0, 32'h8899_A5BB, 1'b0);
    single("sh1a", 1'b1, 2'b01, 1'b0, 6'h1A, 32'hFFFF_7E01, 32'h0000_0000, 1'b0);
    single("lw18", 1'b0, 2'b10, 1'b0, 6'h18, 32'h0, 32'h7E01_0000, 1'b0);

    single("elw12", 1'b0, 2'b10, 1'b0, 6'h12, 32'h0, 32'h0000_0000, 1'b1);
    single("esh15", 1'b1, 2'b01, 1'b0, 6'h15, 32'h0000_1234, 32'h0000_0000, 1'b1);
    single("lw14", 1'b0, 2'b10, 1'b0, 6'h14, 32'h0, 32'h0000_0000, 1'b0);
    single("es20", 1'b1, 2'b11, 1'b0, 6'h20, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    single("lw20", 1'b0, 2'b10, 1'b0, 6'h20, 32'h0, 32'h0000_0000, 1'b0);

    // Back-to-back store then load to the same word.
    drive(1'b1, 2'b10, 1'b0, 6'h20, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("b2b_st_valid", {31'd0, rsp_valid}, 32'd1);
    check("b2b_st_rdata", rsp_rdata, 32'h0000_0000);
    drive(1'b0, 2'b10, 1'b0, 6'h20, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_ld_valid", {31'd0, rsp_valid}, 32'd1);
    check("b2b_ld_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("b2b_ld_error", {31'd0, rsp_error}, 32'd0);
    @(posedge clk); #1;
    check("b2b_idle", {31'd0, rsp_valid}, 32'd0);

    // Reset asserted between edges while a response is pending.
    drive(1'b0, 2'b10, 1'b0, 6'h20, 32'h0);
    @(posedge clk); #1;
    check("mid_valid", {31'd0, rsp_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    req_valid = 1'b0;
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_done", {31'd0, init_done}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    sweep_and_check("resweep");
    single("lw20_clr", 1'b0, 2'b10, 1'b0, 6'h20, 32'h0, 32'h0000_0000, 1'b0);
    single("lw10_clr", 1'b0, 2'b10, 1'b0, 6'h10, 32'h0, 32'h0000_0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
